// File: rtl/button_pkg.sv
// Shared constants for the push-button conditioning logic.
package button_pkg;

    localparam int CLK_HZ              = 50000000;
    localparam int DEBOUNCE_MS         = 10;
    localparam int DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_bit.sv
// Single-channel debouncer: two-flop synchroniser, stability counter,
// accepted-level flop and registered press/release pulses.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pressed_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync0_q;
    logic             sync1_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Bring the asynchronous pin into the clk domain; 0 is the not-pressed level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= pressed_raw_i;
            sync1_q <= sync0_q;
        end
    end

    // Count consecutive mismatching cycles; accept the new level only after a full run, restart on any reversal.
    always_comb begin
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync1_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            stable_d  = sync1_q;
            press_d   = sync1_q;
            release_d = ~sync1_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Register the counter, accepted level and the edge pulses so they change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_debounce.sv
// Conditions WIDTH raw push-button pins into clean active-high levels plus
// one-cycle press/release pulses; channels are fully independent.
module button_debounce
    import button_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [WIDTH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] pressedRaw;

    assign pressedRaw = btn_raw ^ POL_MASK;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk          (clk),
            .reset_n      (reset_n),
            .pressed_raw_i(pressedRaw[i]),
            .level_o      (btn_level[i]),
            .press_o      (btn_press[i]),
            .release_o    (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed testbench for button_debounce with DEBOUNCE_CYCLES=4, WIDTH=5, ACTIVE_LOW=1.
module tb_button_debounce;

    logic       clk;
    logic       reset_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;

    int checksRun;
    int checksPassed;

    button_debounce #(
        .WIDTH          (5),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksRun++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed[4:0], expected[4:0], $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] raw);
        btn_raw = raw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickCheck(input string tag, input logic [4:0] expLevel, input logic [4:0] expPress,
                             input logic [4:0] expRelease);
        tick();
        checkOutput({tag, ".level"}, 32'(btn_level), 32'(expLevel));
        checkOutput({tag, ".press"}, 32'(btn_press), 32'(expPress));
        checkOutput({tag, ".release"}, 32'(btn_release), 32'(expRelease));
    endtask

    // Directed scenarios; all inputs change 1 ns after a rising edge, so the next edge is edge 1.
    initial begin
        checksRun    = 0;
        checksPassed = 0;
        reset_n      = 1'b0;
        applyStimulus(5'b11111);

        repeat (3) tickCheck("reset", 5'b00000, 5'b00000, 5'b00000);
        reset_n = 1'b1;
        repeat (20) tickCheck("idle", 5'b00000, 5'b00000, 5'b00000);

        applyStimulus(5'b11110);
        repeat (5) tickCheck("press_wait", 5'b00000, 5'b00000, 5'b00000);
        tickCheck("press_edge6", 5'b00001, 5'b00001, 5'b00000);
        tickCheck("press_after", 5'b00001, 5'b00000, 5'b00000);

        for (int k = 0; k < 2; k++) begin
            applyStimulus(5'b11010);
            repeat (2) tickCheck("bounce_lo", 5'b00001, 5'b00000, 5'b00000);
            applyStimulus(5'b11110);
            repeat (2) tickCheck("bounce_hi", 5'b00001, 5'b00000, 5'b00000);
        end
        applyStimulus(5'b11010);
        repeat (5) tickCheck("bounce_wait", 5'b00001, 5'b00000, 5'b00000);
        tickCheck("bounce_edge6", 5'b00101, 5'b00100, 5'b00000);
        tickCheck("bounce_after", 5'b00101, 5'b00000, 5'b00000);

        applyStimulus(5'b10010);
        repeat (3) tickCheck("glitch_lo", 5'b00101, 5'b00000, 5'b00000);
        applyStimulus(5'b11010);
        repeat (8) tickCheck("glitch_back", 5'b00101, 5'b00000, 5'b00000);

        applyStimulus(5'b00000);
        repeat (5) tickCheck("all_wait", 5'b00101, 5'b00000, 5'b00000);
        tickCheck("all_edge6", 5'b11111, 5'b11010, 5'b00000);
        repeat (3) tickCheck("all_hold", 5'b11111, 5'b00000, 5'b00000);

        applyStimulus(5'b11111);
        repeat (5) tickCheck("rel_wait", 5'b11111, 5'b00000, 5'b00000);
        tickCheck("rel_edge6", 5'b00000, 5'b00000, 5'b11111);
        tickCheck("rel_after", 5'b00000, 5'b00000, 5'b00000);

        applyStimulus(5'b11110);
        repeat (4) tickCheck("midcnt_wait", 5'b00000, 5'b00000, 5'b00000);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_async.level", 32'(btn_level), 32'd0);
        repeat (2) tickCheck("midrst_hold", 5'b00000, 5'b00000, 5'b00000);
        reset_n = 1'b1;
        repeat (5) tickCheck("midrst_wait", 5'b00000, 5'b00000, 5'b00000);
        tickCheck("midrst_edge6", 5'b00001, 5'b00001, 5'b00000);
        tickCheck("midrst_after", 5'b00001, 5'b00000, 5'b00000);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
Conditions raw mechanical push-button inputs before they reach the button PIO's in_port on the Avalon fabric. Each channel is synchronised to clk and then debounced with a per-channel stability counter. Each channel drives a clean, active-high "pressed" level plus one-cycle press and release pulses for local logic, such as the metering menu FSM. One instance sits between the board KEY pins and the PIO, with width 5 to match the PIO input.

Parameters:
WIDTH, 5, number of button channels
DEBOUNCE_CYCLES, 500000, consecutive clk cycles a new input level must persist before it is accepted (10 ms at 50 MHz); legal range is 1 or more
ACTIVE_LOW, 1, 1 means a raw pin reads 0 when pressed; 0 means a raw pin reads 1 when pressed
CNT_W, $clog2(DEBOUNCE_CYCLES)+1, counter width; derived, not overridden

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
btn_raw  input  WIDTH  asynchronous button pins
btn_level  output  WIDTH  debounced level, 1 = pressed; feeds PIO in_port
btn_press  output  WIDTH  one-cycle pulse when a channel's btn_level goes 0->1
btn_release  output  WIDTH  one-cycle pulse when a channel's btn_level goes 1->0

Behaviour:
- All channels are fully independent; no cross-channel interaction.
- Normalise: pressed_raw[i] = btn_raw[i] XOR ACTIVE_LOW.
- Synchroniser: two flops, sync0 then sync1. Both reset to 0, the not-pressed level.
- State per channel: stable (btn_level) and cnt[CNT_W-1:0]. Both reset to 0.
- Each rising clk edge:
  - If sync1 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync1, cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: the raw level must change before edge 1 and hold. btn_level then changes on edge DEBOUNCE_CYCLES+2. Two of those edges are the synchroniser; the remaining DEBOUNCE_CYCLES are counting.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES cycles after synchronisation returns cnt to 0 and leaves btn_level unchanged. The counting restarts from 0 on any reversal.
- Pulses: btn_press[i] and btn_release[i] are registered. Each is asserted for exactly one cycle, on the same edge that stable flips, in the matching direction. They are never asserted together, and are 0 at all other times.
- Counter saturation is impossible: cnt never exceeds DEBOUNCE_CYCLES-1. CNT_W holds that value.
- DEBOUNCE_CYCLES = 1: a change is accepted on the first mismatched cycle, giving a total latency of 3 edges.
- Reset: asserting reset_n mid-count immediately clears sync0, sync1, stable, cnt and the pulses to 0. After release, a button held through reset is reported as a fresh press after the full latency.
- Multiple channels may flip on the same edge; each pulses independently.
- No combinational path from btn_raw to any output.

Decomposition:
- Shared package button_pkg: the default DEBOUNCE_CYCLES (500000) and the CLK_HZ (50000000) constant it is derived from.
- Sub-module debounce_bit handles one channel: synchroniser, counter, stable flop and pulse flops.
- button_debounce instantiates debounce_bit WIDTH times in a generate loop and applies the ACTIVE_LOW XOR.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, WIDTH=5, ACTIVE_LOW=1.
- Reset: hold reset_n=0 with btn_raw=5'b11111 -> btn_level=0, btn_press=0 and btn_release=0 throughout. All remain 0 for 20 cycles after release.
- Clean press: drive btn_raw[0]=0 before edge 1 and hold -> btn_level[0] rises on edge 6. btn_press[0]=1 for exactly edge 6 to edge 7. Other bits stay 0.
- Bounce: toggle btn_raw[2] 0,1,0,1 every 2 cycles, then hold 0 -> btn_level[2] rises exactly 6 edges after the final transition, with a single btn_press pulse.
- Glitch rejection: btn_raw[3]=0 for 3 cycles, then back to 1 -> btn_level[3] never changes and there are no pulses.
- Release and simultaneous channels: all five pressed and stable, then btn_raw=5'b11111 -> all btn_level fall on the same edge, and btn_release=5'b11111 for one cycle.
- Reset mid-count: assert reset_n=0 while cnt=2 on a pressed channel, then release with the button still held -> cnt restarts from 0. btn_level rises on the 6th edge after reset release.
